// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit accumulator CPU: opcode constants,
// sequencer state encodings and default bus widths.
package cpu_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 13;

  typedef enum logic [2:0] {
    HLT = 3'b000,
    SKZ = 3'b001,
    ADD = 3'b010,
    AND = 3'b011,
    XOR = 3'b100,
    LDA = 3'b101,
    STO = 3'b110,
    JMP = 3'b111
  } opcode_t;

  typedef enum logic [3:0] {
    S0   = 4'd0,
    S1   = 4'd1,
    S2   = 4'd2,
    S3   = 4'd3,
    S4   = 4'd4,
    S5   = 4'd5,
    S6   = 4'd6,
    S7   = 4'd7,
    HALT = 4'd8
  } state_t;

endpackage

// File: rtl/cpu_ir_reg.sv
// Instruction register: two byte-wide load enables and a synchronous clear;
// splits the word into opcode and operand address.
module cpu_ir_reg #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              load_hi,
  input  logic              load_lo,
  input  logic [DATA_W-1:0] data_in,
  output logic [2:0]        opcode,
  output logic [ADDR_W-1:0] ir_addr
);

  logic [2*DATA_W-1:0] ir;

  always_ff @(posedge clk) begin
    if (clear) begin
      ir <= '0;
    end else begin
      if (load_hi) ir[2*DATA_W-1:DATA_W] <= data_in;
      if (load_lo) ir[DATA_W-1:0]        <= data_in;
    end
  end

  assign opcode  = ir[2*DATA_W-1 -: 3];
  assign ir_addr = ir[ADDR_W-1:0];

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/decode sequencer: eight-cycle instruction cycle plus HALT.
// Optional CPU_SEQ_HALT_RESUME_EN adds a resume input that leaves HALT.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
`ifdef CPU_SEQ_HALT_RESUME_EN
  input  logic              resume,
`endif
  input  logic [DATA_W-1:0] data_in,
  input  logic              zero,
  output logic [2:0]        opcode,
  output logic [ADDR_W-1:0] ir_addr,
  output logic              alu_ena,
  output logic              inc_pc,
  output logic              load_pc,
  output logic              load_acc,
  output logic              rd,
  output logic              wr,
  output logic              datactl_ena,
  output logic              halt
);

  state_t            state, next_state;
  logic              zero_p4;
  logic [2:0]        ir_opcode;
  logic [ADDR_W-1:0] ir_addr_raw;
  opcode_t           op;

  cpu_ir_reg #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ir (
    .clk     (clk),
    .clear   (reset),
    .load_hi (state == S0),
    .load_lo (state == S1),
    .data_in (data_in),
    .opcode  (ir_opcode),
    .ir_addr (ir_addr_raw)
  );

  assign op      = opcode_t'(ir_opcode);
  assign opcode  = reset ? 3'b000 : ir_opcode;
  assign ir_addr = reset ? '0 : ir_addr_raw;

  always_ff @(posedge clk) begin
    if (reset) state <= S0;
    else       state <= next_state;
  end

  // SKZ decides in S4; the S5 increment reuses that decision so a skip is always two bytes
  always_ff @(posedge clk) begin
    if (state == S4) zero_p4 <= zero;
  end

  always_comb begin
    next_state = S0;
    case (state)
      S0:   next_state = S1;
      S1:   next_state = S2;
      S2:   next_state = S3;
      S3:   next_state = (op == HLT) ? HALT : S4;
      S4:   next_state = S5;
      S5:   next_state = S6;
      S6:   next_state = S7;
      S7:   next_state = S0;
`ifdef CPU_SEQ_HALT_RESUME_EN
      HALT: next_state = resume ? S0 : HALT;
`else
      HALT: next_state = HALT;
`endif
      default: next_state = S0;
    endcase
  end

  always_comb begin
    rd          = 1'b0;
    wr          = 1'b0;
    inc_pc      = 1'b0;
    load_pc     = 1'b0;
    load_acc    = 1'b0;
    alu_ena     = 1'b0;
    datactl_ena = 1'b0;
    halt        = 1'b0;
    if (!reset) begin
      case (state)
        S0: rd = 1'b1;
        S1: begin
          rd     = 1'b1;
          inc_pc = 1'b1;
        end
        S2: inc_pc = 1'b1;
        S3: alu_ena = 1'b1;
        S4: begin
          case (op)
            ADD, AND, XOR, LDA: rd = 1'b1;
            STO:                datactl_ena = 1'b1;
            JMP:                load_pc = 1'b1;
            SKZ:                inc_pc = zero;
            default: ;
          endcase
        end
        S5: begin
          case (op)
            ADD, AND, XOR, LDA: begin
              rd       = 1'b1;
              load_acc = 1'b1;
            end
            STO: begin
              datactl_ena = 1'b1;
              wr          = 1'b1;
            end
            JMP:     load_pc = 1'b1;
            SKZ:     inc_pc = zero_p4;
            default: ;
          endcase
        end
        S6:   datactl_ena = (op == STO);
        HALT: halt = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: table of instructions with per-state strobe
// expectations, plus HLT, resume and mid-instruction reset sequences.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  data_in;
  logic        zero;
  logic [2:0]  opcode;
  logic [12:0] ir_addr;
  logic        alu_ena, inc_pc, load_pc, load_acc, rd, wr, datactl_ena, halt;
`ifdef CPU_SEQ_HALT_RESUME_EN
  logic        resume;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_sequencer dut (
    .clk         (clk),
    .reset       (reset),
`ifdef CPU_SEQ_HALT_RESUME_EN
    .resume      (resume),
`endif
    .data_in     (data_in),
    .zero        (zero),
    .opcode      (opcode),
    .ir_addr     (ir_addr),
    .alu_ena     (alu_ena),
    .inc_pc      (inc_pc),
    .load_pc     (load_pc),
    .load_acc    (load_acc),
    .rd          (rd),
    .wr          (wr),
    .datactl_ena (datactl_ena),
    .halt        (halt)
  );

  // strobe vector bit order: {rd, wr, inc_pc, load_pc, load_acc, alu_ena, datactl_ena}
  typedef struct {
    logic [7:0]      hi;
    logic [7:0]      lo;
    logic            z4;
    logic            z5;
    logic [2:0]      op;
    logic [12:0]     addr;
    logic [7:0][6:0] exp;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [6:0] strobes();
    return {rd, wr, inc_pc, load_pc, load_acc, alu_ena, datactl_ena};
  endfunction

  function automatic logic [7:0][6:0] mk(input logic [6:0] s4, input logic [6:0] s5,
                                         input logic [6:0] s6);
    return {7'h00, s6, s5, s4, 7'h02, 7'h10, 7'h50, 7'h40};
  endfunction

  function automatic vec_t mkv(input logic [7:0] hi, input logic [7:0] lo, input logic z4,
                               input logic z5, input logic [2:0] op, input logic [12:0] addr,
                               input logic [6:0] s4, input logic [6:0] s5, input logic [6:0] s6);
    vec_t v;
    v.hi = hi; v.lo = lo; v.z4 = z4; v.z5 = z5; v.op = op; v.addr = addr;
    v.exp = mk(s4, s5, s6);
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Runs states S0..S(ncyc-1) of one instruction; entered and left at posedge+1.
  task automatic run_vec(input vec_t v, input string tag, input int ncyc);
    for (int k = 0; k < ncyc; k++) begin
      data_in = (k == 0) ? v.hi : (k == 1) ? v.lo : 8'($urandom);
      zero    = (k == 4) ? v.z4 : (k == 5) ? v.z5 : 1'($urandom);
      #1;
      chk($sformatf("%s S%0d strobes", tag, k), 16'(strobes()), 16'(v.exp[k]));
      chk($sformatf("%s S%0d halt", tag, k), 16'(halt), 16'h0);
      if (k >= 2) begin
        chk($sformatf("%s S%0d opcode", tag, k), 16'(opcode), 16'(v.op));
        chk($sformatf("%s S%0d ir_addr", tag, k), 16'(ir_addr), 16'(v.addr));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic run_hlt(input string tag);
    logic [6:0] pre [4];
    pre = '{7'h40, 7'h50, 7'h10, 7'h02};
    for (int k = 0; k < 4; k++) begin
      data_in = (k < 2) ? 8'h00 : 8'($urandom);
      zero    = 1'($urandom);
      #1;
      chk($sformatf("%s S%0d strobes", tag, k), 16'(strobes()), 16'(pre[k]));
      chk($sformatf("%s S%0d halt", tag, k), 16'(halt), 16'h0);
      @(posedge clk); #1;
    end
    for (int c = 0; c < 22; c++) begin
      data_in = 8'($urandom);
      zero    = 1'($urandom);
      #1;
      chk($sformatf("%s halt c%0d", tag, c), 16'(halt), 16'h1);
      chk($sformatf("%s halt strobes c%0d", tag, c), 16'(strobes()), 16'h0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    vecs[0] = mkv(8'h5A, 8'h0F, 1'b0, 1'b1, 3'b010, 13'h1A0F, 7'h40, 7'h44, 7'h00); // ADD
    vecs[1] = mkv(8'hC0, 8'h10, 1'b1, 1'b1, 3'b110, 13'h0010, 7'h01, 7'h21, 7'h01); // STO
    vecs[2] = mkv(8'h20, 8'h00, 1'b1, 1'b0, 3'b001, 13'h0000, 7'h10, 7'h10, 7'h00); // SKZ skip
    vecs[3] = mkv(8'h20, 8'h00, 1'b0, 1'b1, 3'b001, 13'h0000, 7'h00, 7'h00, 7'h00); // SKZ no skip
    vecs[4] = mkv(8'hE0, 8'h55, 1'b1, 1'b1, 3'b111, 13'h0055, 7'h08, 7'h08, 7'h00); // JMP
    vecs[5] = mkv(8'h61, 8'h23, 1'b0, 1'b0, 3'b011, 13'h0123, 7'h40, 7'h44, 7'h00); // AND
    vecs[6] = mkv(8'hA0, 8'h07, 1'b1, 1'b0, 3'b101, 13'h0007, 7'h40, 7'h44, 7'h00); // LDA
    vecs[7] = mkv(8'h9F, 8'hFF, 1'b0, 1'b1, 3'b100, 13'h1FFF, 7'h40, 7'h44, 7'h00); // XOR

    reset   = 1'b1;
    data_in = 8'hA5;
    zero    = 1'b1;
`ifdef CPU_SEQ_HALT_RESUME_EN
    resume  = 1'b0;
`endif
    @(posedge clk); #1;
    chk("reset strobes", 16'(strobes()), 16'h0);
    chk("reset halt", 16'(halt), 16'h0);
    chk("reset opcode", 16'(opcode), 16'h0);
    chk("reset ir_addr", 16'(ir_addr), 16'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i), 8);

    run_hlt("hlt1");

`ifdef CPU_SEQ_HALT_RESUME_EN
    resume = 1'b1;
    @(posedge clk); #1;
    resume = 1'b0;
    #1;
    chk("resume halt", 16'(halt), 16'h0);
    chk("resume strobes", 16'(strobes()), 16'h40);
    run_vec(vecs[1], "post_resume", 8);
    run_hlt("hlt2");
`endif

    reset = 1'b1;
    #1;
    chk("halt reset gated halt", 16'(halt), 16'h0);
    chk("halt reset gated strobes", 16'(strobes()), 16'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("after halt reset halt", 16'(halt), 16'h0);
    chk("after halt reset strobes", 16'(strobes()), 16'h40);
    run_vec(vecs[0], "post_halt", 8);

    run_vec(vecs[0], "abort", 5);
    reset = 1'b1;
    zero  = 1'b1;
    #1;
    chk("abort S5 strobes", 16'(strobes()), 16'h0);
    chk("abort S5 opcode", 16'(opcode), 16'h0);
    chk("abort S5 ir_addr", 16'(ir_addr), 16'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("abort cleared opcode", 16'(opcode), 16'h0);
    chk("abort cleared ir_addr", 16'(ir_addr), 16'h0);
    chk("abort restart strobes", 16'(strobes()), 16'h40);
    run_vec(vecs[4], "after_abort", 8);
    run_vec(vecs[2], "after_abort2", 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
